dct_1d_column_pipe: RTL and testbench
=====================================

Name: dct_1d_column_pipe

Overview:
- Pipelined, parametrised 8-point 1D DCT column stage for the JPEG datapath.
- Accepts one 8-sample column per beat and computes all eight coefficients with fixed-point constant multiplies. Output coefficients k ≥ KEEP are forced to zero (zonal truncation).
- Supports a per-beat DC scaling mode and a valid/ready handshake with full backpressure.
- Sits between the row-transpose buffer and the quantiser.

Parameters:
- IN_W, 9: signed width of each input sample.
- OUT_W, 10: signed width of each output coefficient.
- OUT_SHIFT, 5: right shift applied to the accumulator for all coefficients in normal mode.
- DC_EXTRA, 2: additional right shift applied to y0 when dc_alt is set.
- KEEP, 8: number of low-order coefficients retained (1..8); y[k] = 0 for k ≥ KEEP.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  8*IN_W  samples; x0 in the MSBs, x7 in the LSBs.
- dc_alt  in  1  sideband sampled with the beat; selects the extra DC shift.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8*OUT_W  coefficients; y0 in the MSBs, y7 in the LSBs.

Behaviour:
- Reset is synchronous and active-high. On reset: all stage valid flags = 0, out_valid = 0, out_data = 0. in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation discards every in-flight beat. No partial output appears afterwards.
- Handshake and stall:
  - A beat transfers when valid && ready on the same edge.
  - out_data and out_valid are held stable while out_valid && !out_ready.
  - Advance condition: advance = !out_valid || out_ready.
  - in_ready = advance. This is a global stall: all stages shift together, there are no bubbles squeezed, and there is no combinational path from in_valid to in_ready.
- Latency is 3 cycles from input transfer to out_valid, with no stalls. Throughput is 1 beat per cycle.
- Stage S1, butterfly:
  - s_n = x_n + x_(7-n) and d_n = x_n − x_(7-n) for n = 0..3, each IN_W+1 bits signed.
  - Also e0 = s0 + s3, e1 = s1 + s2, f0 = s0 − s3, f1 = s1 − s2.
  - dc_alt is registered alongside.
- Stage S2, products:
  - Constant coefficients C1..C7 = 63, 59, 53, 45, 36, 24, 12 (round(64·cos(kπ/16))); C4 = 45 is also used for DC.
  - Multiplies are implemented as shift-add only; no `*` operator.
  - Accumulator width is IN_W + 11 bits signed.
- Stage S3, sums:
  - acc0 = 45·(e0 + e1)
  - acc4 = 45·(e0 − e1)
  - acc2 = 59·f0 + 24·f1
  - acc6 = 24·f0 − 59·f1
  - acc1 = 63·d0 + 53·d1 + 36·d2 + 12·d3
  - acc3 = 53·d0 − 12·d1 − 63·d2 − 36·d3
  - acc5 = 36·d0 − 63·d1 + 12·d2 + 53·d3
  - acc7 = 12·d0 − 36·d1 + 53·d2 − 63·d3
- Rounding and saturation:
  - y_k = sat_OUT_W((acc_k + 2^(SH−1)) >>> SH).
  - SH = OUT_SHIFT for all coefficients, except y0 uses SH = OUT_SHIFT + DC_EXTRA when dc_alt is set.
  - Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1) − 1].
- Zonal truncation: outputs with k ≥ KEEP are the constant 0. Their logic may be pruned.
- Simultaneous in_valid and a stall: in_ready = 0 and no transfer occurs; the upstream holds its data.

Decomposition:
- Shared package dct_pkg holds:
  - The coefficient constants C1..C7.
  - The localparam ACC_W.
  - A saturate/round function used here and by the row stage.
- One natural sub-module, dct_round_sat, instantiated 8×.
  - Parameters: ACC_W, OUT_W.
  - Ports: acc, shift, result.
- The shift-add constant multipliers stay inline in the top.

Test Plan:
- Reset then single beat with all x = 10, dc_alt = 0 → out_valid exactly 3 cycles later; y0 = 113, y1..y7 = 0.
- Same beat with dc_alt = 1 → y0 = 28, y1..y7 = 0.
- Impulse x0 = 100, others 0 → y0..y7 = 141, 197, 184, 166, 141, 113, 75, 38.
- All x = 255 → y0 saturates to 511. All x = −256 → y0 = −512. AC outputs = 0 in both cases.
- Burst of 6 beats with out_ready toggling 1,0,0,1,… → outputs in order, no loss or duplication, out_data stable while stalled, in_ready tracks advance.
- Assert reset with 2 beats in flight → out_valid stays 0 and nothing is emitted. Rerun the impulse case with KEEP = 3 → y0..y2 = 141, 197, 184, y3..y7 = 0.

Source files
------------

// File: rtl/dct_pkg.sv
// dct_pkg: coefficient constants, accumulator width and arithmetic helpers shared by the DCT stages
package dct_pkg;
  localparam int C1 = 63;
  localparam int C2 = 59;
  localparam int C3 = 53;
  localparam int C4 = 45;
  localparam int C5 = 36;
  localparam int C6 = 24;
  localparam int C7 = 12;
  localparam int ACC_GROWTH = 11;
  localparam int ACC_W = 9 + ACC_GROWTH;
  function automatic logic signed [31:0] cmul(input logic signed [31:0] x, input int c);
    logic signed [31:0] p;
    p = '0;
    for (int i = 0; i < 7; i++) if (c[i]) p = p + (x <<< i);
    return p;
  endfunction
  function automatic logic signed [31:0] round_sat(input logic signed [31:0] acc, input logic [4:0] sh, input int out_w);
    logic signed [31:0] r, hi, lo;
    r = (acc + (32'sd1 <<< (sh - 5'd1))) >>> sh;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    return r > hi ? hi : (r < lo ? lo : r);
  endfunction
endpackage

// File: rtl/dct_round_sat.sv
// dct_round_sat: round-half-up arithmetic right shift followed by signed saturation to OUT_W bits
module dct_round_sat
  import dct_pkg::*;
#(
  parameter int ACC_W = dct_pkg::ACC_W,
  parameter int OUT_W = 10
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [4:0]       shift,
  output logic signed [OUT_W-1:0] result
);
  assign result = OUT_W'(round_sat(32'(acc), shift, OUT_W));
endmodule

// File: rtl/dct_1d_column_pipe.sv
// dct_1d_column_pipe: 3-stage 8-point 1D DCT column stage with zonal truncation and a global stall
module dct_1d_column_pipe
  import dct_pkg::*;
#(
  parameter int IN_W      = 9,
  parameter int OUT_W     = 10,
  parameter int OUT_SHIFT = 5,
  parameter int DC_EXTRA  = 2,
  parameter int KEEP      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*IN_W-1:0]  in_data,
  input  logic               dc_alt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*OUT_W-1:0] out_data
);
  localparam int AW = IN_W + ACC_GROWTH;
  localparam int SW = IN_W + 1;
  localparam int EW = IN_W + 2;
  localparam logic [4:0] SH = 5'(OUT_SHIFT);
  localparam logic [4:0] SH_DC = 5'(OUT_SHIFT + DC_EXTRA);
  localparam int KO [4] = '{C1, C3, C5, C7};
  logic adv;
  logic v1_q, v2_q, vo_q, dc1_q, dc2_q;
  logic signed [IN_W-1:0] x [8];
  logic signed [SW-1:0] sum_d [4];
  logic signed [SW-1:0] dif_d [4];
  logic signed [SW-1:0] dif_q [4];
  logic signed [EW-1:0] ev_d [2];
  logic signed [EW-1:0] od_d [2];
  logic signed [EW-1:0] ev_q [2];
  logic signed [EW-1:0] od_q [2];
  logic signed [AW-1:0] pe_d [2];
  logic signed [AW-1:0] pe_q [2];
  logic signed [AW-1:0] pf_d [4];
  logic signed [AW-1:0] pf_q [4];
  logic signed [AW-1:0] pd_d [4][4];
  logic signed [AW-1:0] pd_q [4][4];
  logic signed [AW-1:0] acc [8];
  logic [8*OUT_W-1:0] y_flat, out_q;
  assign adv = !vo_q || out_ready;
  assign in_ready = adv;
  assign out_valid = vo_q;
  assign out_data = out_q;
  for (genvar n = 0; n < 8; n++) begin : g_unpack
    assign x[n] = in_data[(7-n)*IN_W +: IN_W];
  end
  for (genvar n = 0; n < 4; n++) begin : g_bfly
    assign sum_d[n] = SW'(x[n]) + SW'(x[7-n]);
    assign dif_d[n] = SW'(x[n]) - SW'(x[7-n]);
  end
  assign ev_d[0] = EW'(sum_d[0]) + EW'(sum_d[3]);
  assign ev_d[1] = EW'(sum_d[1]) + EW'(sum_d[2]);
  assign od_d[0] = EW'(sum_d[0]) - EW'(sum_d[3]);
  assign od_d[1] = EW'(sum_d[1]) - EW'(sum_d[2]);
  assign pe_d[0] = AW'(cmul(32'(ev_q[0]) + 32'(ev_q[1]), C4));
  assign pe_d[1] = AW'(cmul(32'(ev_q[0]) - 32'(ev_q[1]), C4));
  assign pf_d[0] = AW'(cmul(32'(od_q[0]), C2));
  assign pf_d[1] = AW'(cmul(32'(od_q[1]), C6));
  assign pf_d[2] = AW'(cmul(32'(od_q[0]), C6));
  assign pf_d[3] = AW'(cmul(32'(od_q[1]), C2));
  for (genvar n = 0; n < 4; n++) begin : g_prod
    for (genvar j = 0; j < 4; j++) begin : g_coef
      assign pd_d[n][j] = AW'(cmul(32'(dif_q[n]), KO[j]));
    end
  end
  assign acc[0] = pe_q[0];
  assign acc[4] = pe_q[1];
  assign acc[2] = pf_q[0] + pf_q[1];
  assign acc[6] = pf_q[2] - pf_q[3];
  assign acc[1] = pd_q[0][0] + pd_q[1][1] + pd_q[2][2] + pd_q[3][3];
  assign acc[3] = pd_q[0][1] - pd_q[1][3] - pd_q[2][0] - pd_q[3][2];
  assign acc[5] = pd_q[0][2] - pd_q[1][0] + pd_q[2][3] + pd_q[3][1];
  assign acc[7] = pd_q[0][3] - pd_q[1][2] + pd_q[2][1] - pd_q[3][0];
  for (genvar k = 0; k < 8; k++) begin : g_out
    if (k < KEEP) begin : g_keep
      dct_round_sat #(.ACC_W(AW), .OUT_W(OUT_W)) u_rs (
        .acc(acc[k]),
        .shift((k == 0 && dc2_q) ? SH_DC : SH),
        .result(y_flat[(7-k)*OUT_W +: OUT_W])
      );
    end else begin : g_zero
      assign y_flat[(7-k)*OUT_W +: OUT_W] = '0;
    end
  end
  // stage valids and the output register move together whenever the output can advance
  always_ff @(posedge clk)
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      vo_q <= 1'b0;
      out_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      vo_q <= v2_q;
      out_q <= y_flat;
    end
  // datapath registers need no reset; their contents only matter under the matching valid flag
  always_ff @(posedge clk)
    if (adv) begin
      dc1_q <= dc_alt;
      dif_q <= dif_d;
      ev_q <= ev_d;
      od_q <= od_d;
      dc2_q <= dc1_q;
      pe_q <= pe_d;
      pf_q <= pf_d;
      pd_q <= pd_d;
    end
endmodule

// File: tb/tb_dct_1d_column_pipe.sv
// tb_dct_1d_column_pipe: randomized and directed checks of the DCT column stage against a cosine-matrix model
module tb_dct_1d_column_pipe;
  localparam int IN_W = 9;
  localparam int OUT_W = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic dc_alt = 1'b0;
  logic out_ready = 1'b1;
  logic [8*IN_W-1:0] in_data = '0;
  logic in_ready, out_valid, in_ready3, out_valid3;
  logic [8*OUT_W-1:0] out_data, out_data3;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  dct_1d_column_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dc_alt(dc_alt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  dct_1d_column_pipe #(.KEEP(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .dc_alt(dc_alt), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3)
  );
  // 64*cos(m*pi/16) rounded, using cosine symmetry over a full period
  function automatic int cosq(input int m);
    int t [9];
    t = '{64, 63, 59, 53, 45, 36, 24, 12, 0};
    m = m % 32;
    if (m > 16) m = 32 - m;
    return m > 8 ? -t[16-m] : t[m];
  endfunction
  function automatic logic [8*OUT_W-1:0] model(input logic [8*IN_W-1:0] d, input logic dc, input int keep);
    logic [8*OUT_W-1:0] r;
    logic signed [IN_W-1:0] xs;
    int acc, sh, v, c;
    r = '0;
    for (int k = 0; k < keep; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) begin
        xs = d[(7-n)*IN_W +: IN_W];
        c = (k == 0) ? 45 : cosq((2*n+1)*k);
        acc += c * int'(xs);
      end
      sh = (k == 0 && dc) ? 7 : 5;
      v = (acc + (1 << (sh - 1))) >>> sh;
      v = v > 511 ? 511 : (v < -512 ? -512 : v);
      r[(7-k)*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    return r;
  endfunction
  task automatic send(input logic [8*IN_W-1:0] d, input logic dc,
                      output logic [8*OUT_W-1:0] y, output logic [8*OUT_W-1:0] y3, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = d;
    dc_alt = dc;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    y = out_data;
    y3 = out_data3;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b/%b exp=0", out_valid, out_valid3);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", out_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask
  task automatic test_const();
    logic [8*OUT_W-1:0] y, y3;
    int lat;
    send({8{9'd10}}, 1'b0, y, y3, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL latency got=%0d exp=3", lat);
    end
    checks++;
    if (y !== {10'd113, 70'd0}) begin
      errors++;
      $display("FAIL const10 got=%h exp=%h", y, {10'd113, 70'd0});
    end
    send({8{9'd10}}, 1'b1, y, y3, lat);
    checks++;
    if (y !== {10'd28, 70'd0}) begin
      errors++;
      $display("FAIL const10_dcalt got=%h exp=%h", y, {10'd28, 70'd0});
    end
  endtask
  task automatic test_impulse();
    logic [8*OUT_W-1:0] y, y3;
    int lat;
    send({9'd100, 63'd0}, 1'b0, y, y3, lat);
    checks++;
    if (y !== {10'd141, 10'd197, 10'd184, 10'd166, 10'd141, 10'd113, 10'd75, 10'd38}) begin
      errors++;
      $display("FAIL impulse got=%h exp=%h", y, {10'd141, 10'd197, 10'd184, 10'd166, 10'd141, 10'd113, 10'd75, 10'd38});
    end
    checks++;
    if (y3 !== {10'd141, 10'd197, 10'd184, 50'd0}) begin
      errors++;
      $display("FAIL impulse_keep3 got=%h exp=%h", y3, {10'd141, 10'd197, 10'd184, 50'd0});
    end
  endtask
  task automatic test_saturate();
    logic [8*OUT_W-1:0] y, y3;
    int lat;
    send({8{9'd255}}, 1'b0, y, y3, lat);
    checks++;
    if (y !== {10'd511, 70'd0}) begin
      errors++;
      $display("FAIL sat_pos got=%h exp=%h", y, {10'd511, 70'd0});
    end
    send({8{9'h100}}, 1'b0, y, y3, lat);
    checks++;
    if (y !== {10'h200, 70'd0}) begin
      errors++;
      $display("FAIL sat_neg got=%h exp=%h", y, {10'h200, 70'd0});
    end
  endtask
  task automatic test_random();
    logic [8*OUT_W-1:0] y, y3;
    logic [8*IN_W-1:0] d;
    logic dc;
    int lat;
    for (int i = 0; i < 20; i++) begin
      d = 72'({$urandom(), $urandom(), $urandom()});
      dc = 1'($urandom_range(1));
      send(d, dc, y, y3, lat);
      checks++;
      if (y !== model(d, dc, 8)) begin
        errors++;
        $display("FAIL random%0d got=%h exp=%h", i, y, model(d, dc, 8));
      end
      checks++;
      if (y3 !== model(d, dc, 3)) begin
        errors++;
        $display("FAIL random_keep3_%0d got=%h exp=%h", i, y3, model(d, dc, 3));
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [8*IN_W-1:0] bd [6];
    logic bdc [6];
    logic [8*OUT_W-1:0] exp_q [$];
    logic [8*OUT_W-1:0] held, e;
    logic was_stall;
    int sent, got;
    for (int i = 0; i < 6; i++) begin
      bd[i] = 72'({$urandom(), $urandom(), $urandom()});
      bdc[i] = 1'($urandom_range(1));
    end
    sent = 0;
    got = 0;
    was_stall = 1'b0;
    held = '0;
    @(negedge clk);
    for (int c = 0; c < 200 && got < 6; c++) begin
      out_ready = (c % 3 == 0);
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_data = bd[sent];
        dc_alt = bdc[sent];
      end
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready_track cycle=%0d got=%b exp=%b", c, in_ready, !out_valid || out_ready);
      end
      if (was_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL stall_hold cycle=%0d got=%b/%h exp=1/%h", c, out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        if (out_data !== e) begin
          errors++;
          $display("FAIL burst_out%0d got=%h exp=%h", got, out_data, e);
        end
        got++;
      end
      was_stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, dc_alt, 8));
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 6 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL burst_count got=%0d pending=%0d exp=6/0", got, exp_q.size());
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_extra got=%b exp=0", out_valid);
    end
  endtask
  task automatic test_reset_inflight();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = {8{9'd10}};
    dc_alt = 1'b0;
    @(negedge clk);
    in_data = {9'd100, 63'd0};
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b0 || out_valid3 !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush cycle=%0d got=%b/%b exp=0", i, out_valid, out_valid3);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_const();
    test_impulse();
    test_saturate();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
